// File: rtl/nasti_read_arbiter.sv
// N_PORT-to-1 round-robin arbiter for the NASTI AR/R read path, one burst in flight.
// Define NASTI_RD_ARB_PORT_ID_EN to tag m_ar_id with the port index and route R by id.
module nasti_read_arbiter #(
  parameter int N_PORT     = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  localparam int IDX_W     = (N_PORT > 1) ? $clog2(N_PORT) : 1,
`ifdef NASTI_RD_ARB_PORT_ID_EN
  localparam int MID_W     = ID_WIDTH + IDX_W
`else
  localparam int MID_W     = ID_WIDTH
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORT*ID_WIDTH-1:0]   s_ar_id,
  input  logic [N_PORT*ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [N_PORT*8-1:0]          s_ar_len,
  input  logic [N_PORT*3-1:0]          s_ar_size,
  input  logic [N_PORT*2-1:0]          s_ar_burst,
  input  logic [N_PORT*USER_WIDTH-1:0] s_ar_user,
  input  logic [N_PORT-1:0]            s_ar_valid,
  output logic [N_PORT-1:0]            s_ar_ready,
  output logic [N_PORT*ID_WIDTH-1:0]   s_r_id,
  output logic [N_PORT*DATA_WIDTH-1:0] s_r_data,
  output logic [N_PORT*2-1:0]          s_r_resp,
  output logic [N_PORT-1:0]            s_r_last,
  output logic [N_PORT*USER_WIDTH-1:0] s_r_user,
  output logic [N_PORT-1:0]            s_r_valid,
  input  logic [N_PORT-1:0]            s_r_ready,
  output logic [MID_W-1:0]             m_ar_id,
  output logic [ADDR_WIDTH-1:0]        m_ar_addr,
  output logic [7:0]                   m_ar_len,
  output logic [2:0]                   m_ar_size,
  output logic [1:0]                   m_ar_burst,
  output logic [USER_WIDTH-1:0]        m_ar_user,
  output logic                         m_ar_valid,
  input  logic                         m_ar_ready,
  input  logic [MID_W-1:0]             m_r_id,
  input  logic [DATA_WIDTH-1:0]        m_r_data,
  input  logic [1:0]                   m_r_resp,
  input  logic                         m_r_last,
  input  logic [USER_WIDTH-1:0]        m_r_user,
  input  logic                         m_r_valid,
  output logic                         m_r_ready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] last_grant_reg, last_grant_next;
  logic [IDX_W-1:0] rr_cand [N_PORT];
  logic [IDX_W-1:0] rr_pick;
  logic [IDX_W-1:0] route_idx;
  logic             any_req;

  logic [ID_WIDTH-1:0]   ar_id   [N_PORT];
  logic [ADDR_WIDTH-1:0] ar_addr [N_PORT];
  logic [7:0]            ar_len  [N_PORT];
  logic [2:0]            ar_size [N_PORT];
  logic [1:0]            ar_burst[N_PORT];
  logic [USER_WIDTH-1:0] ar_user [N_PORT];
  logic [N_PORT-1:0]     r_hit, ready_hit;

  for (genvar gi = 0; gi < N_PORT; gi++) begin : g_port
    assign ar_id[gi]    = s_ar_id[gi*ID_WIDTH +: ID_WIDTH];
    assign ar_addr[gi]  = s_ar_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign ar_len[gi]   = s_ar_len[gi*8 +: 8];
    assign ar_size[gi]  = s_ar_size[gi*3 +: 3];
    assign ar_burst[gi] = s_ar_burst[gi*2 +: 2];
    assign ar_user[gi]  = s_ar_user[gi*USER_WIDTH +: USER_WIDTH];

    // rr_cand[gi] is the port examined at priority position gi after last_grant
    assign rr_cand[gi] = IDX_W'((32'(last_grant_reg) + gi + 1) % N_PORT);

    assign s_ar_ready[gi] = (state_reg == ADDR) && (grant_reg == IDX_W'(gi)) && m_ar_ready;
    assign r_hit[gi]      = (state_reg == DATA) && (route_idx == IDX_W'(gi));
    assign s_r_valid[gi]  = r_hit[gi] && m_r_valid;
    assign ready_hit[gi]  = r_hit[gi] && s_r_ready[gi];

    assign s_r_id[gi*ID_WIDTH +: ID_WIDTH]       = m_r_id[ID_WIDTH-1:0];
    assign s_r_data[gi*DATA_WIDTH +: DATA_WIDTH] = m_r_data;
    assign s_r_resp[gi*2 +: 2]                   = m_r_resp;
    assign s_r_last[gi]                          = m_r_last;
    assign s_r_user[gi*USER_WIDTH +: USER_WIDTH] = m_r_user;
  end

`ifdef NASTI_RD_ARB_PORT_ID_EN
  assign m_ar_id   = {grant_reg, ar_id[grant_reg]};
  assign route_idx = m_r_id[MID_W-1 -: IDX_W];
`else
  assign m_ar_id   = ar_id[grant_reg];
  assign route_idx = grant_reg;
`endif

  assign m_ar_addr  = ar_addr[grant_reg];
  assign m_ar_len   = ar_len[grant_reg];
  assign m_ar_size  = ar_size[grant_reg];
  assign m_ar_burst = ar_burst[grant_reg];
  assign m_ar_user  = ar_user[grant_reg];
  assign m_ar_valid = (state_reg == ADDR);
  assign m_r_ready  = |ready_hit;
  assign any_req    = |s_ar_valid;

  // Scan from the lowest priority position down so the highest-priority requester wins.
  always_comb begin
    rr_pick = '0;
    for (int k = N_PORT - 1; k >= 0; k--) begin
      if (s_ar_valid[rr_cand[k]]) rr_pick = rr_cand[k];
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: if (any_req) begin
        grant_next = rr_pick;
        state_next = ADDR;
      end
      ADDR: if (m_ar_ready) state_next = DATA;
      DATA: if (m_r_valid && m_r_ready && m_r_last) begin
        last_grant_next = grant_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IDX_W'(N_PORT - 1);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  a_ar_held: assert property (@(posedge clk) disable iff (rst)
    (state_reg == ADDR) |-> s_ar_valid[grant_reg]);
  a_r_in_data: assert property (@(posedge clk) disable iff (rst)
    m_r_valid |-> (state_reg == DATA));
`ifdef NASTI_RD_ARB_PORT_ID_EN
  a_r_id_port: assert property (@(posedge clk) disable iff (rst)
    ((state_reg == DATA) && m_r_valid) |-> (m_r_id[MID_W-1 -: IDX_W] == grant_reg));
`endif

endmodule

// File: tb/tb_nasti_read_arbiter.sv
// Randomized bench for nasti_read_arbiter: 4 ports, transaction-level round-robin reference model.
module tb_nasti_read_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int UW = 1;
  localparam int XW = 2;
`ifdef NASTI_RD_ARB_PORT_ID_EN
  localparam int MW = IW + XW;
`else
  localparam int MW = IW;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N*IW-1:0] s_ar_id;
  logic [N*AW-1:0] s_ar_addr;
  logic [N*8-1:0]  s_ar_len;
  logic [N*3-1:0]  s_ar_size;
  logic [N*2-1:0]  s_ar_burst;
  logic [N*UW-1:0] s_ar_user;
  logic [N-1:0]    s_ar_valid, s_ar_ready;
  logic [N*IW-1:0] s_r_id;
  logic [N*DW-1:0] s_r_data;
  logic [N*2-1:0]  s_r_resp;
  logic [N-1:0]    s_r_last;
  logic [N*UW-1:0] s_r_user;
  logic [N-1:0]    s_r_valid, s_r_ready;
  logic [MW-1:0]   m_ar_id, m_r_id;
  logic [AW-1:0]   m_ar_addr;
  logic [7:0]      m_ar_len;
  logic [2:0]      m_ar_size;
  logic [1:0]      m_ar_burst, m_r_resp;
  logic [UW-1:0]   m_ar_user, m_r_user;
  logic            m_ar_valid, m_ar_ready, m_r_last, m_r_valid, m_r_ready;
  logic [DW-1:0]   m_r_data;

  always #5 clk = ~clk;

  nasti_read_arbiter #(.N_PORT(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst),
    .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_user(s_ar_user), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_user(s_r_user), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_user(m_ar_user), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_user(m_r_user), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
  );

  int total = 0;
  int bad   = 0;

  // reference model: pending requests per port and the burst currently being served
  bit          pend [N];
  logic [IW-1:0] f_id [N];
  logic [AW-1:0] f_addr [N];
  logic [7:0]  f_len [N];
  logic [2:0]  f_size [N];
  logic [1:0]  f_burst [N];
  logic [UW-1:0] f_user [N];
  int          last_grant, cur, phase, beats_left, beat_no, bursts_done, hold_ar;
  bit          auto_req;
  logic [MW-1:0] cur_mid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_next();
    for (int k = 1; k <= N; k++) begin
      if (pend[(last_grant + k) % N]) return (last_grant + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [MW-1:0] exp_mid(input int p);
`ifdef NASTI_RD_ARB_PORT_ID_EN
    return {XW'(p), f_id[p]};
`else
    return f_id[p];
`endif
  endfunction

  task automatic request(input logic [N-1:0] mask, input int max_len);
    for (int p = 0; p < N; p++) begin
      if (mask[p]) begin
        pend[p]    = 1'b1;
        f_id[p]    = IW'($urandom);
        f_addr[p]  = AW'($urandom);
        f_len[p]   = 8'($urandom_range(0, max_len));
        f_size[p]  = 3'($urandom);
        f_burst[p] = 2'($urandom);
        f_user[p]  = UW'($urandom);
      end
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    last_grant = N - 1;
    phase      = 0;
    cur        = 0;
    beats_left = 0;
    beat_no    = 0;
  endtask

  task automatic pack_ar();
    bit none;
    none = 1'b1;
    for (int p = 0; p < N; p++) if (pend[p]) none = 1'b0;
    if (auto_req && phase == 0 && none && $urandom_range(0, 3) != 0)
      request(N'($urandom_range(1, (1 << N) - 1)), 3);
    for (int p = 0; p < N; p++) begin
      s_ar_valid[p]               = pend[p];
      s_ar_id[p*IW +: IW]         = f_id[p];
      s_ar_addr[p*AW +: AW]       = f_addr[p];
      s_ar_len[p*8 +: 8]          = f_len[p];
      s_ar_size[p*3 +: 3]         = f_size[p];
      s_ar_burst[p*2 +: 2]        = f_burst[p];
      s_ar_user[p*UW +: UW]       = f_user[p];
    end
  endtask

  task automatic drive_inputs();
    pack_ar();
    if (phase == 1 && hold_ar > 0) begin
      m_ar_ready = 1'b0;
      hold_ar--;
    end else begin
      m_ar_ready = 1'($urandom);
    end
    s_r_ready = N'($urandom);
    m_r_data  = DW'($urandom);
    m_r_resp  = 2'($urandom);
    m_r_user  = UW'($urandom);
    if (phase == 2 && $urandom_range(0, 3) != 0) begin
      m_r_valid = 1'b1;
      m_r_id    = cur_mid;
      m_r_last  = (beats_left == 1);
    end else begin
      m_r_valid = 1'b0;
      m_r_id    = MW'($urandom);
      m_r_last  = 1'b0;
    end
  endtask

  task automatic evaluate();
    logic [N-1:0] e_sar, e_srv;
    e_sar = '0;
    e_srv = '0;
    if (phase == 1 && m_ar_ready) e_sar[cur] = 1'b1;
    if (phase == 2 && m_r_valid)  e_srv[cur] = 1'b1;
    check("m_ar_valid", m_ar_valid, phase == 1);
    check("s_ar_ready", s_ar_ready, e_sar);
    check("s_r_valid", s_r_valid, e_srv);
    check("m_r_ready", m_r_ready, phase == 2 && s_r_ready[cur]);
    case (phase)
      0: begin
        cur = rr_next();
        if (cur >= 0) phase = 1;
        else cur = 0;
      end
      1: begin
        check("m_ar_id", m_ar_id, exp_mid(cur));
        check("m_ar_addr", m_ar_addr, f_addr[cur]);
        check("m_ar_len", m_ar_len, f_len[cur]);
        check("m_ar_size", m_ar_size, f_size[cur]);
        check("m_ar_burst", m_ar_burst, f_burst[cur]);
        check("m_ar_user", m_ar_user, f_user[cur]);
        if (m_ar_ready) begin
          pend[cur]  = 1'b0;
          cur_mid    = exp_mid(cur);
          beats_left = int'(f_len[cur]) + 1;
          beat_no    = 0;
          phase      = 2;
        end
      end
      default: begin
        if (m_r_valid && s_r_ready[cur]) begin
          check("s_r_data", s_r_data[cur*DW +: DW], m_r_data);
          check("s_r_id", s_r_id[cur*IW +: IW], f_id[cur]);
          check("s_r_resp", s_r_resp[cur*2 +: 2], m_r_resp);
          check("s_r_user", s_r_user[cur*UW +: UW], m_r_user);
          check("s_r_last", s_r_last[cur], beats_left == 1);
          beats_left--;
          beat_no++;
          if (beats_left == 0) begin
            $display("burst port=%0d beats=%0d addr=%0h t=%0t", cur, beat_no, f_addr[cur], $time);
            last_grant = cur;
            phase      = 0;
            bursts_done++;
          end
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    drive_inputs();
    #1;
    evaluate();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(input int bound);
    int i;
    bit busy;
    i = 0;
    busy = 1'b1;
    while (busy && i < bound) begin
      step();
      i++;
      busy = (phase != 0);
      for (int p = 0; p < N; p++) if (pend[p]) busy = 1'b1;
    end
    check("drain_timeout", busy, 1'b0);
  endtask

  initial begin
    int start;
    auto_req    = 1'b0;
    hold_ar     = 0;
    bursts_done = 0;
    cur_mid     = '0;
    for (int p = 0; p < N; p++) begin
      f_id[p] = '0; f_addr[p] = '0; f_len[p] = '0;
      f_size[p] = '0; f_burst[p] = '0; f_user[p] = '0;
    end
    model_reset();
    rst = 1'b1;
    pack_ar();
    m_ar_ready = 1'b0; s_r_ready = '0; m_r_valid = 1'b0; m_r_id = '0;
    m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0; m_r_user = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_ar_valid", m_ar_valid, 1'b0);
    check("rst_m_r_ready", m_r_ready, 1'b0);
    check("rst_s_ar_ready", s_ar_ready, '0);
    check("rst_s_r_valid", s_r_valid, '0);
    @(negedge clk);
    rst = 1'b0;

    // lone port 0 burst of 4 beats at 0x10
    request(4'b0001, 0);
    f_addr[0] = 8'h10;
    f_len[0]  = 8'd3;
    run_until_idle(200);
    check("single_bursts", bursts_done, 1);

    // all ports, single beats: expect 1,2,3,0 after last grant 0
    request(4'b1111, 0);
    run_until_idle(300);
    check("rotate_bursts", bursts_done, 5);
    check("rotate_last", last_grant, 0);

    // ports 1 and 3 after last grant 2: port 3 first, AR held off 5 cycles
    request(4'b0100, 0);
    run_until_idle(200);
    hold_ar = 5;
    request(4'b1010, 1);
    run_until_idle(300);
    check("pair_last", last_grant, 1);

    auto_req = 1'b1;
    start = bursts_done;
    run(2000);
    auto_req = 1'b0;
    run_until_idle(300);
    check("random_progress", bursts_done > start + 50, 1'b1);

    // reset in the middle of a 4-beat burst
    request(4'b0001, 0);
    f_len[0] = 8'd3;
    begin
      int i;
      i = 0;
      while (!(phase == 2 && beat_no >= 1) && i < 300) begin
        step();
        i++;
      end
      check("mid_burst_timeout", phase == 2 && beat_no >= 1, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_m_ar_valid", m_ar_valid, 1'b0);
    check("async_m_r_ready", m_r_ready, 1'b0);
    check("async_s_ar_ready", s_ar_ready, '0);
    check("async_s_r_valid", s_r_valid, '0);
    model_reset();
    pack_ar();
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start = bursts_done;
    request(4'b0001, 1);
    run_until_idle(200);
    check("post_reset_burst", bursts_done, start + 1);
    check("post_reset_last", last_grant, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nasti_read_arbiter.md
Name: nasti_read_arbiter

Overview:
- N_PORT-to-1 arbiter for the NASTI read path (AR and R channels).
- Shares one downstream slave port between N_PORT upstream masters using round-robin grant.
- Allows exactly one outstanding read burst at a time.
- Sits between per-core NASTI masters and a shared memory/IO slave; the write path is handled by a separate block.

Parameters:
N_PORT, 2, number of upstream master ports (>=1)
ID_WIDTH, 1, AR/R id width per port
ADDR_WIDTH, 8, address width
DATA_WIDTH, 8, data width
USER_WIDTH, 1, user field width (>0)
IDX_W, $clog2(N_PORT) (min 1), port index width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_ar_id  in  N_PORT*ID_WIDTH  upstream AR id, port p at slice p
s_ar_addr  in  N_PORT*ADDR_WIDTH  upstream AR address
s_ar_len  in  N_PORT*8  burst length-1
s_ar_size  in  N_PORT*3  beat size
s_ar_burst  in  N_PORT*2  burst type
s_ar_user  in  N_PORT*USER_WIDTH  AR user
s_ar_valid  in  N_PORT  AR valid
s_ar_ready  out  N_PORT  AR ready
s_r_id  out  N_PORT*ID_WIDTH  R id
s_r_data  out  N_PORT*DATA_WIDTH  R data
s_r_resp  out  N_PORT*2  R response
s_r_last  out  N_PORT  R last
s_r_user  out  N_PORT*USER_WIDTH  R user
s_r_valid  out  N_PORT  R valid
s_r_ready  in  N_PORT  R ready
m_ar_id  out  ID_WIDTH (+IDX_W, see Optional Feature)  downstream AR id
m_ar_addr/len/size/burst/user  out  matching single-port widths  downstream AR fields
m_ar_valid  out  1  downstream AR valid
m_ar_ready  in  1  downstream AR ready
m_r_id  in  same as m_ar_id  downstream R id
m_r_data/resp/last/user  in  single-port widths  downstream R fields
m_r_valid  in  1  downstream R valid
m_r_ready  out  1  downstream R ready

Behaviour:
- One clock domain, clk. Reset rst is asynchronous, active-high.
- Lock, cache, prot, qos and region are not carried; the integrating top ties them off at the slave.
- State machine: IDLE, ADDR, DATA.
- Registers: state, grant[IDX_W-1:0], last_grant.
- Reset values:
  - state = IDLE, grant = 0, last_grant = N_PORT-1, so port 0 wins first.
  - All outputs 0: m_ar_valid, m_r_ready, s_ar_ready, s_r_valid.
- IDLE:
  - If any s_ar_valid is set, grant = first set bit searching last_grant+1, +2, ... modulo N_PORT; go to ADDR.
  - No outputs are asserted in IDLE.
  - Latency: s_ar_valid to m_ar_valid is 1 cycle.
- ADDR:
  - m_ar_* = fields of port grant (combinational mux; the master holds them stable per protocol).
  - m_ar_valid = 1.
  - s_ar_ready[grant] = m_ar_ready; all other s_ar_ready = 0.
  - On m_ar_valid & m_ar_ready, go to DATA.
- DATA:
  - s_r_valid[grant] = m_r_valid; m_r_ready = s_r_ready[grant].
  - Other ports see s_r_valid = 0. R payload fields are broadcast to all ports.
  - On an R handshake with m_r_last = 1: last_grant = grant, go to IDLE.
  - This gives a 1-cycle bubble between bursts.
- Fairness: with all ports requesting continuously, grants rotate 0,1,...,N_PORT-1,0...
- N_PORT=1: grant is always 0 and the FSM is unchanged.
- Upstream s_ar_valid deasserted while in ADDR without a handshake is a protocol violation. Behaviour is undefined and covered by an assertion.
- An R beat with m_r_valid in IDLE or ADDR is a slave violation. m_r_ready = 0 there; assertion.
- Reset asserted mid-burst: immediate return to the reset state; the in-flight burst is abandoned.

Optional Feature:
- Macro: NASTI_RD_ARB_PORT_ID_EN.
- Defined:
  - m_ar_id / m_r_id widen to ID_WIDTH+IDX_W; upper IDX_W bits = grant.
  - R routing uses m_r_id upper bits instead of the grant register.
  - s_r_id = m_r_id lower ID_WIDTH bits.
  - Assertion: in DATA, m_r_id upper bits == grant.
- Undefined:
  - m_ar_id / m_r_id are ID_WIDTH wide, passed through unchanged.
  - R routing uses the grant register only.

Test Plan:
- Reset, then port0 AR addr=0x10 len=3 alone -> m_ar_valid rises 1 cycle after s_ar_valid, addr 0x10; 4 R beats reach port0 only; last on beat 4; FSM back to IDLE.
- N_PORT=4, all ports request continuously with len=0 -> grant order 0,1,2,3,0; each port gets exactly 1 of every 4 bursts.
- Ports 1 and 3 request after last_grant=2 -> port 3 granted first, then port 1.
- R backpressure: s_r_ready[grant] toggles 1,0,1,0 over a len=1 burst -> m_r_ready mirrors it; 2 beats delivered with no loss or duplication.
- Downstream m_ar_ready held 0 for 5 cycles -> m_ar_valid and fields stay stable; s_ar_ready stays 0 until m_ar_ready rises.
- Reset asserted during beat 2 of a len=3 burst -> all valids/readies 0 asynchronously; after release, a port0 request is granted normally.
- With NASTI_RD_ARB_PORT_ID_EN: port 2 id=1 -> m_ar_id = {2'b10,1'b1}; R id {2'b10,1'b1} returns s_r_id=1 at port 2.
